// File: rtl/gemm_job_scheduler.sv
// Round-robin front end that time-shares one GEMM multiplier among several requesters,
// holding the granted tiles stable, returning tagged results and flushing a hung datapath.
module gemm_job_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int DIM            = 16,
    parameter int WIDTH          = 8,
    parameter int OUT_BITS       = 2 * WIDTH,
    parameter int TIMEOUT_CYCLES = 512
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ*DIM*DIM*WIDTH-1:0]  req_a,
    input  logic [NUM_REQ*DIM*DIM*WIDTH-1:0]  req_b,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]        rsp_id,
    output logic [DIM*DIM*OUT_BITS-1:0]       rsp_data,
    output logic                              rsp_err,
    output logic [DIM*DIM*WIDTH-1:0]          mul_in0,
    output logic [DIM*DIM*WIDTH-1:0]          mul_in1,
    output logic                              mul_in_valid,
    input  logic [DIM*DIM*OUT_BITS-1:0]       mul_out,
    input  logic                              mul_finished,
    output logic                              mul_reset_n,
    output logic                              busy,
    output logic [15:0]                       jobs_done
);
    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int TILE_W = DIM * DIM * WIDTH;
    localparam int WD_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_BUSY  = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]           state;
    logic [ID_W-1:0]      rr_ptr;
    logic [WD_W-1:0]      wd_cnt;
    logic [2*NUM_REQ-1:0] rot_valid;
    logic                 grant_found;
    logic [ID_W-1:0]      grant_idx;
    logic [ID_W:0]        cand_sum;
    logic [TILE_W-1:0]    sel_a;
    logic [TILE_W-1:0]    sel_b;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] idx);
        if (idx == ID_W'(NUM_REQ - 1))
            return '0;
        return idx + 1'b1;
    endfunction

    // Rotating the doubled request vector puts the rr pointer at bit 0, so the
    // lowest set bit within the first NUM_REQ positions is the round-robin winner.
    assign rot_valid = {req_valid, req_valid} >> rr_ptr;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && rot_valid[i]) begin
                grant_found = 1'b1;
                cand_sum    = {1'b0, rr_ptr} + (ID_W+1)'(i);
                if (cand_sum >= (ID_W+1)'(NUM_REQ))
                    cand_sum = cand_sum - (ID_W+1)'(NUM_REQ);
                grant_idx = cand_sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_a = req_a[i*TILE_W +: TILE_W];
                sel_b = req_b[i*TILE_W +: TILE_W];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!reset && state == S_IDLE && grant_found)
            req_ready[grant_idx] = 1'b1;
    end

    assign mul_in_valid = (state == S_START);
    assign rsp_valid    = (state == S_RESP);
    assign busy         = (state != S_IDLE);
    assign mul_reset_n  = ~reset & (state != S_FLUSH);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            wd_cnt    <= '0;
            mul_in0   <= '0;
            mul_in1   <= '0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            jobs_done <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        mul_in0 <= sel_a;
                        mul_in1 <= sel_b;
                        rsp_id  <= grant_idx;
                        rr_ptr  <= wrap_inc(grant_idx);
                        state   <= S_START;
                    end
                end
                S_START: begin
                    wd_cnt <= '0;
                    state  <= S_BUSY;
                end
                S_BUSY: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    // A completion on the last watchdog cycle still counts as success.
                    if (mul_finished) begin
                        rsp_data <= mul_out;
                        rsp_err  <= 1'b0;
                        state    <= S_RESP;
                    end else if (wd_cnt == WD_LAST) begin
                        state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    rsp_data <= '0;
                    rsp_err  <= 1'b1;
                    state    <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        jobs_done <= jobs_done + 16'd1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
